// File: rtl/sr_pq_param.sv
// Shift-register priority queue: sorted cell array with the head in cell 0.
// Define SR_PQ_DISPLACE_EN to let a higher-priority enq evict the tail when full.
package pq_pkg;
  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;
endpackage

module sr_pq_param #(
  parameter int DEPTH     = 8,
  parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
  parameter int MIN_FIRST = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_enq,
  input  logic                           i_deq,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] i_kvi,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] o_kvo,
  output logic                           o_ovalid,
  output logic                           o_empty,
  output logic                           o_full,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_ovf
`ifdef SR_PQ_DISPLACE_EN
  ,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] o_drop_kv,
  output logic                           o_drop_valid
`endif
);

  localparam int KVW = KEY_WIDTH + VAL_WIDTH;
  localparam int CW  = $clog2(DEPTH + 1);

  logic [KEY_WIDTH-1:0] r_key [DEPTH];
  logic [VAL_WIDTH-1:0] r_val [DEPTH];
  logic [DEPTH-1:0]     r_vld;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;

  logic [KEY_WIDTH-1:0] w_bKey [DEPTH];
  logic [VAL_WIDTH-1:0] w_bVal [DEPTH];
  logic [DEPTH-1:0]     w_bVld;
  logic [DEPTH-1:0]     w_behind;
  logic [KEY_WIDTH-1:0] w_nKey [DEPTH];
  logic [VAL_WIDTH-1:0] w_nVal [DEPTH];
  logic [DEPTH-1:0]     w_nVld;
  logic [KEY_WIDTH-1:0] w_newKey;
  logic [VAL_WIDTH-1:0] w_newVal;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_doDeq;
  logic                 w_doEnq;
  logic                 w_displace;
  logic                 w_ovf;
  logic [CW-1:0]        w_nCount;

  // True when a cell holding key a sits strictly below a new entry with key b.
  function automatic logic lowerPri(input logic [KEY_WIDTH-1:0] a,
                                    input logic [KEY_WIDTH-1:0] b);
    return (MIN_FIRST != 0) ? (a > b) : (a < b);
  endfunction

  assign w_newKey = i_kvi[KVW-1 -: KEY_WIDTH];
  assign w_newVal = i_kvi[VAL_WIDTH-1:0];
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_doDeq  = i_deq && !w_empty;

`ifdef SR_PQ_DISPLACE_EN
  assign w_displace = i_enq && w_full && !w_doDeq && lowerPri(r_key[DEPTH-1], w_newKey);
`else
  assign w_displace = 1'b0;
`endif

  assign w_doEnq = i_enq && (!w_full || w_doDeq || w_displace);
  assign w_ovf   = i_enq && !w_doEnq;

  always_comb begin
    w_nCount = r_count;
    if (w_doEnq && !w_doDeq && !w_full) w_nCount = r_count + CW'(1);
    else if (w_doDeq && !w_doEnq)       w_nCount = r_count - CW'(1);
  end

  // A dequeue first shifts everything toward the head; insertion then works on that base.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_bKey[i] = w_doDeq ? r_key[i+1] : r_key[i];
      w_bVal[i] = w_doDeq ? r_val[i+1] : r_val[i];
      w_bVld[i] = w_doDeq ? r_vld[i+1] : r_vld[i];
    end
    w_bKey[DEPTH-1] = w_doDeq ? '0   : r_key[DEPTH-1];
    w_bVal[DEPTH-1] = w_doDeq ? '0   : r_val[DEPTH-1];
    w_bVld[DEPTH-1] = w_doDeq ? 1'b0 : r_vld[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      w_behind[i] = w_bVld[i] && !lowerPri(w_bKey[i], w_newKey);
    end
  end

  // Cells ahead of the insertion point hold, the slot takes the new entry, the rest shift back.
  always_comb begin
    if (w_doEnq && !w_behind[0]) begin
      w_nKey[0] = w_newKey;
      w_nVal[0] = w_newVal;
      w_nVld[0] = 1'b1;
    end else begin
      w_nKey[0] = w_bKey[0];
      w_nVal[0] = w_bVal[0];
      w_nVld[0] = w_bVld[0];
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (!w_doEnq || w_behind[i]) begin
        w_nKey[i] = w_bKey[i];
        w_nVal[i] = w_bVal[i];
        w_nVld[i] = w_bVld[i];
      end else if (w_behind[i-1]) begin
        w_nKey[i] = w_newKey;
        w_nVal[i] = w_newVal;
        w_nVld[i] = 1'b1;
      end else begin
        w_nKey[i] = w_bKey[i-1];
        w_nVal[i] = w_bVal[i-1];
        w_nVld[i] = w_bVld[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_key[i] <= '0;
        r_val[i] <= '0;
      end
      r_vld   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_key[i] <= w_nKey[i];
        r_val[i] <= w_nVal[i];
      end
      r_vld   <= w_nVld;
      r_count <= w_nCount;
      r_ovf   <= w_ovf;
    end
  end

`ifdef SR_PQ_DISPLACE_EN
  logic [KVW-1:0] r_dropKv;
  logic           r_dropValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropKv    <= '0;
      r_dropValid <= 1'b0;
    end else begin
      r_dropKv    <= w_displace ? {r_key[DEPTH-1], r_val[DEPTH-1]} : '0;
      r_dropValid <= w_displace;
    end
  end

  assign o_drop_kv    = r_dropKv;
  assign o_drop_valid = r_dropValid;
`endif

  assign o_kvo    = {r_key[0], r_val[0]};
  assign o_ovalid = r_vld[0];
  assign o_count  = r_count;
  assign o_empty  = w_empty;
  assign o_full   = w_full;
  assign o_ovf    = r_ovf;

endmodule

// File: tb/tb_sr_pq_param.sv
// Bench for sr_pq_param (DEPTH=4, MIN_FIRST=1): vector table, corner sequences, random vs queue model.
// Follows SR_PQ_DISPLACE_EN when the design is built with it.
module tb_sr_pq_param;

  localparam int DEPTH = 4;
  localparam int KW    = 8;
  localparam int VW    = 8;

  typedef struct packed {
    logic [KW-1:0] k;
    logic [VW-1:0] v;
  } ent_t;

  typedef struct {
    logic          enq;
    logic          deq;
    logic [KW-1:0] k;
    logic [VW-1:0] v;
    logic          expValid;
    logic [KW-1:0] expK;
    logic [VW-1:0] expV;
    int            expCount;
    logic          expOvf;
  } vec_t;

  logic               clk;
  logic               rst_n;
  logic               enq;
  logic               deq;
  logic [KW+VW-1:0]   kvi;
  logic [KW+VW-1:0]   kvo;
  logic               ovalid;
  logic               empty;
  logic               full;
  logic [2:0]         count;
  logic               ovf;
`ifdef SR_PQ_DISPLACE_EN
  logic [KW+VW-1:0]   dropKv;
  logic               dropValid;
`endif

  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];
  ent_t mq[$];

  sr_pq_param #(.DEPTH(DEPTH), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .MIN_FIRST(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enq    (enq),
    .i_deq    (deq),
    .i_kvi    (kvi),
    .o_kvo    (kvo),
    .o_ovalid (ovalid),
    .o_empty  (empty),
    .o_full   (full),
    .o_count  (count),
    .o_ovf    (ovf)
`ifdef SR_PQ_DISPLACE_EN
    ,
    .o_drop_kv    (dropKv),
    .o_drop_valid (dropValid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, let one rising edge pass, return at the next falling edge.
  task automatic applyStimulus(input logic e, input logic d, input logic [KW-1:0] k, input logic [VW-1:0] v);
    enq = e;
    deq = d;
    kvi = {k, v};
    @(negedge clk);
    enq = 1'b0;
    deq = 1'b0;
    kvi = '0;
  endtask

  task automatic addVec(input logic e, input logic d, input int k, input int v,
                        input logic ev, input int ek, input int evl, input int ec, input logic eo);
    vec_t t;
    t.enq = e; t.deq = d; t.k = KW'(k); t.v = VW'(v);
    t.expValid = ev; t.expK = KW'(ek); t.expV = VW'(evl);
    t.expCount = ec; t.expOvf = eo;
    tbl.push_back(t);
  endtask

  task automatic checkHead(input string name, input int ek, input int ev, input int ec);
    checkOutput({name, ".ovalid"}, 32'(ovalid), 32'd1);
    checkOutput({name, ".kvo"}, 32'(kvo), 32'({KW'(ek), VW'(ev)}));
    checkOutput({name, ".count"}, 32'(count), 32'(ec));
  endtask

  task automatic insertSorted(input ent_t e);
    int idx = 0;
    while (idx < mq.size() && mq[idx].k <= e.k) idx++;
    mq.insert(idx, e);
  endtask

  task automatic modelStep(input logic e, input logic d, input ent_t n,
                           output logic eOvf, output logic eDv, output ent_t eDkv);
    eOvf = 1'b0;
    eDv  = 1'b0;
    eDkv = '0;
    if (d && mq.size() > 0) void'(mq.pop_front());
    if (e) begin
      if (mq.size() < DEPTH) insertSorted(n);
      else begin
`ifdef SR_PQ_DISPLACE_EN
        if (n.k < mq[mq.size()-1].k) begin
          eDv  = 1'b1;
          eDkv = mq[mq.size()-1];
          void'(mq.pop_back());
          insertSorted(n);
        end else eOvf = 1'b1;
`else
        eOvf = 1'b1;
`endif
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enq   = 1'b0;
    deq   = 1'b0;
    kvi   = '0;

    #12;
    checkOutput("rst.ovalid", 32'(ovalid), 32'd0);
    checkOutput("rst.empty",  32'(empty),  32'd1);
    checkOutput("rst.full",   32'(full),   32'd0);
    checkOutput("rst.count",  32'(count),  32'd0);
    checkOutput("rst.ovf",    32'(ovf),    32'd0);
    checkOutput("rst.kvo",    32'(kvo),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //      enq deq key val  valid ek  ev cnt ovf
    addVec(1, 0,  8, 14, 1,  8, 14, 1, 0);
    addVec(1, 0, 14, 14, 1,  8, 14, 2, 0);
    addVec(1, 0,  9, 10, 1,  8, 14, 3, 0);
    addVec(0, 1,  0,  0, 1,  9, 10, 2, 0);
    addVec(0, 1,  0,  0, 1, 14, 14, 1, 0);
    addVec(0, 1,  0,  0, 0,  0,  0, 0, 0);
    addVec(0, 1,  0,  0, 0,  0,  0, 0, 0);
    addVec(1, 0,  9, 10, 1,  9, 10, 1, 0);
    addVec(1, 0,  9, 11, 1,  9, 10, 2, 0);
    addVec(1, 0,  9, 12, 1,  9, 10, 3, 0);
    addVec(0, 1,  0,  0, 1,  9, 11, 2, 0);
    addVec(0, 1,  0,  0, 1,  9, 12, 1, 0);
    addVec(0, 1,  0,  0, 0,  0,  0, 0, 0);
    addVec(1, 0, 30,  1, 1, 30,  1, 1, 0);
    addVec(1, 0,  5,  2, 1,  5,  2, 2, 0);
    addVec(1, 0, 55,  3, 1,  5,  2, 3, 0);
    addVec(1, 0,  9,  4, 1,  5,  2, 4, 0);

    foreach (tbl[i]) begin
      string n;
      n = $sformatf("vec%0d", i);
      applyStimulus(tbl[i].enq, tbl[i].deq, tbl[i].k, tbl[i].v);
      checkOutput({n, ".ovalid"}, 32'(ovalid), 32'(tbl[i].expValid));
      checkOutput({n, ".count"},  32'(count),  32'(tbl[i].expCount));
      checkOutput({n, ".ovf"},    32'(ovf),    32'(tbl[i].expOvf));
      checkOutput({n, ".empty"},  32'(empty),  32'(tbl[i].expCount == 0));
      checkOutput({n, ".full"},   32'(full),   32'(tbl[i].expCount == DEPTH));
      if (tbl[i].expValid)
        checkOutput({n, ".kvo"}, 32'(kvo), 32'({tbl[i].expK, tbl[i].expV}));
    end

`ifdef SR_PQ_DISPLACE_EN
    applyStimulus(1, 0, 1, 1);
    checkOutput("disp.dropValid", 32'(dropValid), 32'd1);
    checkOutput("disp.dropKv", 32'(dropKv), 32'({8'd55, 8'd3}));
    checkOutput("disp.ovf", 32'(ovf), 32'd0);
    checkHead("disp", 1, 1, 4);
    applyStimulus(1, 0, 60, 9);
    checkOutput("rej.ovf", 32'(ovf), 32'd1);
    checkOutput("rej.dropValid", 32'(dropValid), 32'd0);
    checkOutput("rej.dropKv", 32'(dropKv), 32'd0);
    checkHead("rej", 1, 1, 4);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rej.ovfPulse", 32'(ovf), 32'd0);
    applyStimulus(0, 1, 0, 0);
    checkHead("drainD1", 5, 2, 3);
    applyStimulus(0, 1, 0, 0);
    checkHead("drainD2", 9, 4, 2);
    applyStimulus(0, 1, 0, 0);
    checkHead("drainD3", 30, 1, 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("drainD4.empty", 32'(empty), 32'd1);
`else
    applyStimulus(1, 0, 1, 7);
    checkOutput("ovf.ovf", 32'(ovf), 32'd1);
    checkHead("ovf", 5, 2, 4);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ovf.pulse", 32'(ovf), 32'd0);
    applyStimulus(1, 1, 16, 16);
    checkHead("swap", 9, 4, 4);
    checkOutput("swap.ovf", 32'(ovf), 32'd0);
    applyStimulus(0, 1, 0, 0);
    checkHead("drain1", 16, 16, 3);
    applyStimulus(0, 1, 0, 0);
    checkHead("drain2", 30, 1, 2);
    applyStimulus(0, 1, 0, 0);
    checkHead("drain3", 55, 3, 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("drain4.empty", 32'(empty), 32'd1);
`endif

    applyStimulus(1, 0, 3, 1);
    applyStimulus(1, 0, 7, 2);
    applyStimulus(1, 0, 2, 3);
    checkHead("pre_rst", 2, 3, 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst.empty",  32'(empty),  32'd1);
    checkOutput("arst.ovalid", 32'(ovalid), 32'd0);
    checkOutput("arst.count",  32'(count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 0, 0);
    checkOutput("deqEmpty.count", 32'(count), 32'd0);
    checkOutput("deqEmpty.ovf",   32'(ovf),   32'd0);
    checkOutput("deqEmpty.ovalid", 32'(ovalid), 32'd0);
    applyStimulus(1, 1, 4, 4);
    checkHead("enqDeqEmpty", 4, 4, 1);

    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      logic e, d, eOvf, eDv;
      ent_t n, eDkv;
      string nm;
      e = ($urandom_range(0, 99) < 60);
      d = ($urandom_range(0, 99) < 40);
      n.k = KW'($urandom_range(0, 15));
      n.v = VW'($urandom);
      modelStep(e, d, n, eOvf, eDv, eDkv);
      applyStimulus(e, d, n.k, n.v);
      nm = $sformatf("rnd%0d", c);
      checkOutput({nm, ".count"},  32'(count),  32'(mq.size()));
      checkOutput({nm, ".ovalid"}, 32'(ovalid), 32'(mq.size() > 0));
      checkOutput({nm, ".ovf"},    32'(ovf),    32'(eOvf));
      if (mq.size() > 0) checkOutput({nm, ".kvo"}, 32'(kvo), 32'(mq[0]));
`ifdef SR_PQ_DISPLACE_EN
      checkOutput({nm, ".dropValid"}, 32'(dropValid), 32'(eDv));
      checkOutput({nm, ".dropKv"},    32'(dropKv),    32'(eDkv));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_pq_param.md
SR_PQ_PARAM -- requirements
Module: sr_pq_param

Interface
REQ-001 Parameter DEPTH, default 8: number of storage cells, at least 2.
REQ-002 Parameter KEY_WIDTH, default pq_pkg KEY_WIDTH: priority key width.
REQ-003 Parameter VAL_WIDTH, default pq_pkg VAL_WIDTH: payload width.
REQ-004 Parameter MIN_FIRST, default 1: 1 means the smallest key is highest priority; 0 means the largest key is highest priority.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 enq  in  1  insert request; kvi is sampled in the same cycle.
REQ-008 deq  in  1  remove the head entry.
REQ-009 kvi  in  KEY_WIDTH+VAL_WIDTH  {key,val} to insert; key in the MSBs.
REQ-010 kvo  out  KEY_WIDTH+VAL_WIDTH  head entry (cell 0), registered.
REQ-011 ovalid  out  1  kvo holds a valid entry.
REQ-012 empty  out  1  count == 0.
REQ-013 full  out  1  count == DEPTH.
REQ-014 count  out  $clog2(DEPTH+1)  number of occupied cells.
REQ-015 ovf  out  1  one-cycle pulse: an enq was rejected.

Function
REQ-016 Storage SHALL be a linear array of DEPTH cells, each holding {valid, key, val}; cell 0 is the head; valid cells SHALL stay contiguous from cell 0 and sorted by priority.
REQ-017 Enq only, not full: new entry goes into the first cell whose key is strictly lower priority; that cell and all later cells shift one toward the tail; visible on kvo the next cycle if it becomes the head.
REQ-018 Equal keys SHALL be FIFO: a new entry is placed behind all existing entries with equal key.
REQ-019 Deq only, not empty: all cells shift one toward the head; the tail cell is invalidated; count decrements.
REQ-020 Deq when empty SHALL be ignored with no state change and no flag.
REQ-021 Enq and deq in the same cycle, not empty: the current head is removed and the new entry is inserted among the remaining entries in one cycle; count is unchanged; this is legal when full.
REQ-022 Enq and deq in the same cycle, empty: deq is ignored and the enq proceeds as in REQ-017.
REQ-023 Enq only when full: rejected, no state change, ovf=1 for one cycle (see REQ-030 for the exception).
REQ-024 All outputs SHALL be driven from registers or from count decode; there is no combinational path from enq, deq or kvi to any output.
REQ-025 Key comparison SHALL be unsigned over KEY_WIDTH bits; val never affects ordering.

Reset
REQ-026 rst_n low SHALL immediately clear all valid bits and count; outputs take ovalid=0, empty=1, full=0, count=0, ovf=0, kvo=0.
REQ-027 Reset asserted mid-operation SHALL discard all entries, with no partial shift completed.
REQ-028 Operations SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro SR_PQ_DISPLACE_EN enables displacement on full.
REQ-030 With SR_PQ_DISPLACE_EN defined: an enq-only while full, with key strictly higher priority than the tail, inserts the new entry and evicts the tail; drop_kv (KEY_WIDTH+VAL_WIDTH, out) holds the evicted entry and drop_valid (1, out) pulses for one cycle; ovf=0.
REQ-031 With SR_PQ_DISPLACE_EN defined: an enq-only while full, with key equal or lower priority, is rejected with ovf pulsed; drop_valid and drop_kv reset to 0.
REQ-032 Without SR_PQ_DISPLACE_EN: the drop_kv and drop_valid ports are absent and REQ-023 applies unconditionally.

Verification (DEPTH=4, MIN_FIRST=1, macro off unless stated)
REQ-033 Reset, then enq (8,14), (14,14), (9,10) -> kvo=(8,14), count=3, empty=0, full=0.
REQ-034 Enq (9,10), (9,11), (9,12) -> deq three times returns vals 10, 11, 12 in order (FIFO ties).
REQ-035 Fill with keys 5, 9, 30, 55; enq key 1 -> ovf pulses; contents and count=4 unchanged.
REQ-036 Full queue with keys 5, 9, 30, 55; simultaneous enq (16,16) and deq -> next cycle kvo key=9, contents 9, 16, 30, 55, count=4.
REQ-037 Macro on, full with keys 5, 9, 30, 55; enq (1,1) -> drop_valid with drop_kv key=55, kvo key=1; then enq key 60 -> ovf pulses.
REQ-038 rst_n pulsed low mid-stream while 3 entries are held -> empty=1 and ovalid=0 asynchronously; then deq on an empty queue -> no change and no ovf.
